// File: rtl/rca_scheduler_if.sv
// rca_scheduler_if: request, adder and response channels of the shared-adder scheduler
interface rca_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int WORDS = 2,
    parameter int IDW   = 3
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*WORDS*16-1:0] req_a;
    logic [NREQ*WORDS*16-1:0] req_b;
    logic [NREQ-1:0]          req_cin;
    logic [15:0]              rca_a;
    logic [15:0]              rca_b;
    logic                     rca_cin;
    logic [15:0]              rca_s;
    logic                     rca_cout;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic [WORDS*16-1:0]      rsp_sum;
    logic                     rsp_cout;
    logic                     busy;

    modport master (
        output req_valid, req_a, req_b, req_cin, rca_s, rca_cout, rsp_ready,
        input  req_ready, rca_a, rca_b, rca_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rca_s, rca_cout, rsp_ready,
        output req_ready, rca_a, rca_b, rca_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );
endinterface

// File: rtl/rca_scheduler.sv
// rca_scheduler: round-robin sharing of one 16-bit ripple-carry adder for wide adds
module rca_scheduler #(
    parameter int NREQ  = 4,
    parameter int WORDS = 2,
    parameter int IDW   = 3
) (
    input logic clk,
    input logic rst_n,
    rca_scheduler_if.slave bus
);
    localparam int W  = WORDS * 16;
    localparam int XW = WORDS > 1 ? $clog2(WORDS) : 1;

    if (NREQ < 2 || NREQ > 8 || WORDS < 1 || WORDS > 4 || (1 << IDW) < NREQ) begin : g_bad_param
        $error("rca_scheduler: illegal NREQ/WORDS/IDW combination");
    end

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id;
    logic [IDW-1:0] gnt;
    logic [XW-1:0]  idx;
    logic           carry;
    logic           any;
    logic           cin_g;
    logic [W-1:0]   a_g;
    logic [W-1:0]   b_g;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   sum_q;
    int             d;
    int             best;

    // round-robin pick: smallest distance past ptr wins, operands of the winner muxed alongside
    always_comb begin
        best  = NREQ;
        d     = 0;
        gnt   = '0;
        cin_g = 1'b0;
        a_g   = '0;
        b_g   = '0;
        for (int i = 0; i < NREQ; i++) begin
            d = (i + 2 * NREQ - int'(ptr) - 1) % NREQ;
            if (bus.req_valid[i] && d < best) begin
                best  = d;
                gnt   = IDW'(i);
                cin_g = bus.req_cin[i];
                a_g   = bus.req_a[i*W +: W];
                b_g   = bus.req_b[i*W +: W];
            end
        end
    end

    assign any           = |bus.req_valid;
    assign bus.req_ready = (state == IDLE && any && rst_n) ? NREQ'(1) << gnt : '0;
    assign bus.rca_a     = state == CALC ? a_q[idx*16 +: 16] : '0;
    assign bus.rca_b     = state == CALC ? b_q[idx*16 +: 16] : '0;
    assign bus.rca_cin   = state == CALC && carry;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_id    = id;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = state == RESP && carry;
    assign bus.busy      = state != IDLE;

    // grant, slice-by-slice carry chain through the external adder, then hold the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= IDW'(NREQ - 1);
            id    <= '0;
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    a_q   <= a_g;
                    b_q   <= b_g;
                    carry <= cin_g;
                    id    <= gnt;
                    ptr   <= gnt;
                    idx   <= '0;
                    state <= CALC;
                end
                CALC: begin
                    sum_q[idx*16 +: 16] <= bus.rca_s;
                    carry <= bus.rca_cout;
                    idx   <= idx + 1'b1;
                    if (idx == XW'(WORDS - 1)) state <= RESP;
                end
                RESP: if (bus.rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rca_scheduler.sv
// tb_rca_scheduler: directed checks of grant order, carry chaining, backpressure and reset abort
module tb_rca_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_err = 0;
    int n_chk = 0;
    int seen;
    int e;
    int exp_id [5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    rca_scheduler_if #(.NREQ(4), .WORDS(2), .IDW(3)) b0 ();
    rca_scheduler_if #(.NREQ(4), .WORDS(1), .IDW(3)) b1 ();

    assign {b0.rca_cout, b0.rca_s} = 17'(b0.rca_a) + 17'(b0.rca_b) + 17'(b0.rca_cin);
    assign {b1.rca_cout, b1.rca_s} = 17'(b1.rca_a) + 17'(b1.rca_b) + 17'(b1.rca_cin);

    rca_scheduler #(.NREQ(4), .WORDS(2), .IDW(3)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    rca_scheduler #(.NREQ(4), .WORDS(1), .IDW(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        b0.req_valid = '0; b0.req_a = '0; b0.req_b = '0; b0.req_cin = '0; b0.rsp_ready = 1'b0;
        b1.req_valid = '0; b1.req_a = '0; b1.req_b = '0; b1.req_cin = '0; b1.rsp_ready = 1'b0;
        #2;
        chk("reset_busy", b0.busy, 0);
        chk("reset_ready", b0.req_ready, 0);
        chk("reset_rsp_valid", b0.rsp_valid, 0);
        chk("reset_outs", {b0.rca_a, b0.rca_b, b0.rca_cin, b0.rsp_sum, b0.rsp_id, b0.rsp_cout}, 0);
        @(negedge clk) rst_n = 1'b1;

        // single add on requester 2: low slice carries into high slice
        b0.req_a[2*32 +: 32] = 32'h0000FFFF;
        b0.req_b[2*32 +: 32] = 32'h00000001;
        b0.req_valid = 4'b0100;
        #1 chk("t1_ready", b0.req_ready, 4'b0100);
        @(negedge clk) b0.req_valid = '0;
        chk("t1_calc0_busy_ready", {b0.busy, b0.req_ready}, {1'b1, 4'b0000});
        chk("t1_calc0_adder", {b0.rca_a, b0.rca_b, b0.rca_cin}, {16'hFFFF, 16'h0001, 1'b0});
        chk("t1_calc0_valid", b0.rsp_valid, 0);
        @(negedge clk);
        chk("t1_calc1_adder", {b0.rca_a, b0.rca_b, b0.rca_cin}, {16'h0000, 16'h0000, 1'b1});
        chk("t1_calc1_valid", b0.rsp_valid, 0);
        @(negedge clk);
        chk("t1_rsp", {b0.rsp_valid, b0.rsp_id, b0.rsp_sum, b0.rsp_cout}, {1'b1, 3'd2, 32'h00010000, 1'b0});
        chk("t1_adder_idle", {b0.rca_a, b0.rca_b, b0.rca_cin}, 0);
        b0.rsp_ready = 1'b1;
        @(negedge clk) b0.rsp_ready = 1'b0;
        chk("t1_done", {b0.rsp_valid, b0.busy}, 0);

        // overflow on requester 1, then 10 stalled cycles with requester 3 waiting
        b0.req_a[1*32 +: 32] = 32'hFFFFFFFF;
        b0.req_b[1*32 +: 32] = 32'h00000000;
        b0.req_cin[1] = 1'b1;
        b0.req_valid = 4'b0010;
        #1 chk("t2_ready", b0.req_ready, 4'b0010);
        @(negedge clk) b0.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("t2_rsp", {b0.rsp_valid, b0.rsp_id, b0.rsp_sum, b0.rsp_cout}, {1'b1, 3'd1, 32'h0, 1'b1});
        b0.req_a[3*32 +: 32] = 32'h00000001;
        b0.req_b[3*32 +: 32] = 32'h00000002;
        b0.req_valid = 4'b1000;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_hold", {b0.rsp_valid, b0.rsp_id, b0.rsp_cout, b0.rsp_sum, b0.busy, b0.req_ready},
                {1'b1, 3'd1, 1'b1, 32'h0, 1'b1, 4'b0000});
        end
        b0.rsp_ready = 1'b1;
        @(negedge clk) b0.rsp_ready = 1'b0;
        chk("bp_released", b0.rsp_valid, 0);
        chk("bp_waiting_grant", b0.req_ready, 4'b1000);
        @(negedge clk) b0.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("t3_rsp", {b0.rsp_valid, b0.rsp_id, b0.rsp_sum, b0.rsp_cout}, {1'b1, 3'd3, 32'h00000003, 1'b0});
        b0.rsp_ready = 1'b1;
        @(negedge clk);

        // round robin with all four requesters held valid
        for (int i = 0; i < 4; i++) begin
            b0.req_a[i*32 +: 32] = {16'(i), 16'hFFFF};
            b0.req_b[i*32 +: 32] = 32'(i + 1);
        end
        b0.req_cin = '0;
        b0.req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            e = exp_id[n];
            #1 chk("rr_ready", b0.req_ready, 64'(4'b0001 << e));
            @(negedge clk);
            if (n == 4) b0.req_valid = '0;
            chk("rr_calc_ready", b0.req_ready, 0);
            @(negedge clk);
            @(negedge clk);
            chk("rr_id", {b0.rsp_valid, b0.rsp_id}, {1'b1, 3'(e)});
            chk("rr_sum", b0.rsp_sum, {16'(e + 1), 16'(e)});
            @(negedge clk);
        end
        b0.rsp_ready = 1'b0;

        // reset during the first CALC cycle aborts the request
        b0.req_a[2*32 +: 32] = 32'h00000005;
        b0.req_b[2*32 +: 32] = 32'h00000006;
        b0.req_valid = 4'b0100;
        #1 chk("rst_pre_ready", b0.req_ready, 4'b0100);
        @(negedge clk) b0.req_valid = '0;
        chk("rst_calc_busy", b0.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", b0.busy, 0);
        chk("rst_adder", {b0.rca_a, b0.rca_b, b0.rca_cin}, 0);
        chk("rst_rsp", {b0.rsp_valid, b0.rsp_id, b0.rsp_sum, b0.rsp_cout}, 0);
        chk("rst_ready", b0.req_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (6) @(negedge clk) if (b0.rsp_valid) seen++;
        chk("rst_no_rsp", seen, 0);
        b0.req_valid = 4'b1001;
        #1 chk("rst_first_grant", b0.req_ready, 4'b0001);
        @(negedge clk) b0.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_next_rsp", {b0.rsp_valid, b0.rsp_id}, {1'b1, 3'd0});
        b0.rsp_ready = 1'b1;
        @(negedge clk) b0.rsp_ready = 1'b0;

        // single-slice configuration: 0x8000 + 0x8000
        b1.req_a[15:0] = 16'h8000;
        b1.req_b[15:0] = 16'h8000;
        b1.req_valid = 4'b0001;
        #1 chk("w1_ready", b1.req_ready, 4'b0001);
        @(negedge clk) b1.req_valid = '0;
        chk("w1_calc_valid", b1.rsp_valid, 0);
        @(negedge clk);
        chk("w1_rsp", {b1.rsp_valid, b1.rsp_id, b1.rsp_sum, b1.rsp_cout}, {1'b1, 3'd0, 16'h0000, 1'b1});
        b1.rsp_ready = 1'b1;
        @(negedge clk) b1.rsp_ready = 1'b0;
        chk("w1_done", {b1.rsp_valid, b1.busy}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
